// File: rtl/posit_decode_pipe_if.sv
// Stream bundle for the posit decoder: posit words in, decoded fields out.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface posit_decode_pipe_if #(
    parameter int N  = 64,
    parameter int ES = 4
);
    localparam int RS = $clog2(N) + 1;
    localparam int FS = N - ES - 3;
    // A zero-width exponent field is carried as one constant-zero bit
    localparam int EW = (ES > 0) ? ES : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_posit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [RS-1:0] out_regi;
    logic [EW-1:0]        out_expo;
    logic [FS-1:0]        out_frac;
    logic                 out_zero;
    logic                 out_nar;

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_regi, out_expo, out_frac, out_zero, out_nar
    );

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_regi, out_expo, out_frac, out_zero, out_nar
    );
endinterface

// File: rtl/posit_decode_pipe.sv
// Three-stage posit decoder: magnitude, regime run-length, field extraction.
// Valid/ready handshake on both sides with bubble collapse between stages.
module posit_decode_pipe #(
    parameter int N  = 64,
    parameter int ES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    posit_decode_pipe_if.slave   bus
);
    localparam int RS = $clog2(N) + 1;
    localparam int FS = N - ES - 3;
    localparam int EW = (ES > 0) ? ES : 1;
    localparam logic signed [RS-1:0] ONE = 1;

    // Low N-1 bits of the two's complement equal the negation of the low N-1 bits
    function automatic logic [N-2:0] abs_mag(input logic [N-1:0] p);
        return p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
    endfunction

    function automatic logic [RS-1:0] run_len(input logic [N-2:0] mag);
        logic          stop;
        logic [RS-1:0] cnt;
        stop = 1'b0;
        cnt  = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (mag[i] == mag[N-2]))
                cnt = cnt + 1'b1;
            else
                stop = 1'b1;
        end
        return cnt;
    endfunction

    logic                 vld_p1, vld_p2, vld_p3;
    logic                 ld_p1, ld_p2, ld_p3, adv_p3;
    logic                 sign_p1, zero_p1, nar_p1;
    logic [N-2:0]         mag_p1;
    logic                 sign_p2, zero_p2, nar_p2;
    logic [N-2:0]         mag_p2;
    logic [RS-1:0]        m_p2;
    logic                 sign_p3, zero_p3, nar_p3;
    logic signed [RS-1:0] regi_p3;
    logic [EW-1:0]        expo_p3;
    logic [FS-1:0]        frac_p3;

    logic signed [RS-1:0] k_c;
    logic [N-2:0]         sh_c;
    logic [N-4:0]         body_c;
    logic [EW-1:0]        expo_c;
    logic [FS-1:0]        frac_c;
    logic                 unused_sh;

    assign adv_p3       = vld_p3 & bus.out_ready;
    assign ld_p3        = vld_p2 & (~vld_p3 | adv_p3);
    assign ld_p2        = vld_p1 & (~vld_p2 | ld_p3);
    assign bus.in_ready = ~vld_p1 | ld_p2;
    assign ld_p1        = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (ld_p1)      vld_p1 <= 1'b1;
            else if (ld_p2) vld_p1 <= 1'b0;
            if (ld_p2)      vld_p2 <= 1'b1;
            else if (ld_p3) vld_p2 <= 1'b0;
            if (ld_p3)       vld_p3 <= 1'b1;
            else if (adv_p3) vld_p3 <= 1'b0;
        end
    end

    // S1: sign, magnitude and special-value flags
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            sign_p1 <= bus.in_posit[N-1];
            mag_p1  <= abs_mag(bus.in_posit);
            zero_p1 <= (bus.in_posit == '0);
            nar_p1  <= (bus.in_posit == {1'b1, {(N-1){1'b0}}});
        end
    end

    // S2: regime run length
    always_ff @(posedge clk) begin
        if (ld_p2) begin
            sign_p2 <= sign_p1;
            mag_p2  <= mag_p1;
            m_p2    <= run_len(mag_p1);
            zero_p2 <= zero_p1;
            nar_p2  <= nar_p1;
        end
    end

    // S3: strip regime plus terminator; what remains is exponent then fraction
    assign k_c       = mag_p2[N-2] ? ($signed(m_p2) - ONE) : -$signed(m_p2);
    assign sh_c      = mag_p2 << (m_p2 + 1'b1);
    assign body_c    = sh_c[N-2:2];
    assign unused_sh = ^sh_c[1:0];
    assign frac_c    = body_c[FS-1:0];

    generate
        if (ES > 0) begin : g_expo
            assign expo_c = body_c[N-4 -: EW];
        end else begin : g_no_expo
            assign expo_c = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_p3 <= 1'b0;
            regi_p3 <= '0;
            expo_p3 <= '0;
            frac_p3 <= '0;
            zero_p3 <= 1'b0;
            nar_p3  <= 1'b0;
        end else if (ld_p3) begin
            sign_p3 <= sign_p2;
            zero_p3 <= zero_p2;
            nar_p3  <= nar_p2;
            if (zero_p2 || nar_p2) begin
                regi_p3 <= '0;
                expo_p3 <= '0;
                frac_p3 <= '0;
            end else begin
                regi_p3 <= k_c;
                expo_p3 <= expo_c;
                frac_p3 <= frac_c;
            end
        end
    end

    assign bus.out_valid = vld_p3;
    assign bus.out_sign  = sign_p3;
    assign bus.out_regi  = regi_p3;
    assign bus.out_expo  = expo_p3;
    assign bus.out_frac  = frac_p3;
    assign bus.out_zero  = zero_p3;
    assign bus.out_nar   = nar_p3;
endmodule
